vc_allocator_rr: RTL
====================

// Module: vc_allocator_rr
// PURPOSE
// - Next-generation NIC virtual-channel allocator: grants output-buffer requesters a downstream VC from a per-requester candidate mask.
// - Separable two-stage round-robin allocation:
//   - stage 1: each requester picks one VC, round-robin among its candidates;
//   - stage 2: each VC picks one requester, round-robin among those that picked it.
// - Keeps its own VC ownership table: a VC stays owned from grant until release (tail flit sent), so it is never double-allocated.
// - Sits between the NIC out-buffer FIFOs and the link/flit mux.
// PARAMETERS
// - N_OF_REQUEST         3                        requesters (out-buffer FIFOs)
// - N_BITS_N_OF_REQUEST  clog2(N_OF_REQUEST)      requester index width
// - N_OF_VN              2                        virtual networks
// - N_OF_VC              2                        VCs per VN
// - N_TOT_OF_VC          N_OF_VN*N_OF_VC          total VCs; VC v belongs to VN v/N_OF_VC
// PORTS
// - clk                   in   1                          clock, rising edge
// - rst                   in   1                          reset, asynchronous, active-high
// - r_va_i                in   N_OF_REQUEST               requester i wants a VC
// - r_vc_requested_i      in   N_OF_REQUEST*N_TOT_OF_VC   candidate VC mask; requester i at [i*N_TOT_OF_VC +: N_TOT_OF_VC]
// - fifo_pointer_state_i  in   N_TOT_OF_VC                1 = downstream VC busy/full, not allocatable this cycle
// - release_vc_i          in   N_TOT_OF_VC                1 = tail flit sent on VC v, free it
// - g_va_o                out  N_OF_REQUEST               grant to requester i
// - g_vc_id_o             out  N_OF_REQUEST*N_TOT_OF_VC   one-hot granted VC per requester, same packing as the candidate mask
// - vc_owned_o            out  N_TOT_OF_VC                ownership table
// BEHAVIOUR
// - Reset (async):
//   - owned=0; g_va_o=0; g_vc_id_o=0.
//   - All requester pointers select VC0 first; all VC pointers select requester 0 first.
// - avail[v] = !owned[v] & !fifo_pointer_state_i[v].
// - Stage 1, requester i:
//   - Eligible only if r_va_i[i]=1; a nonzero mask with r_va_i=0 is ignored.
//   - cand = mask_i & avail. Picks the first set bit at or after its pointer, wrapping at N_TOT_OF_VC-1 -> 0.
// - Stage 2, VC v: among requesters that picked v, picks the first at or after VC pointer v, with wrap.
// - Grant:
//   - g_va_o[i]=1 and g_vc_id_o slice i is one-hot v; at most one VC per requester and one requester per VC.
//   - A requester that loses stage 2 gets no grant this cycle; no second-choice retry in the same cycle.
// - On each rising edge, per grant (i,v):
//   - owned[v]<=1;
//   - requester pointer i <= (v+1) mod N_TOT_OF_VC;
//   - VC pointer v <= (i+1) mod N_OF_REQUEST.
//   - Pointers without a grant hold.
// - Release: release_vc_i[v] clears owned[v] at the edge. The VC is allocatable from the next cycle, never in the release cycle.
// - Release of an unowned VC is ignored. Grant and release can never target the same VC in one cycle, since owned is not avail.
// - Requesters must drop r_va_i the cycle after a grant; a held request competes again as a new packet.
// - Mask bits at or above N_TOT_OF_VC do not exist; a candidate mask of zero means no grant.
// - Latency, default: g_va_o/g_vc_id_o are combinational from inputs and state (same-cycle grant).
// CONFIGURATION
// - VA_OUT_REG_EN undefined: same-cycle combinational grant, as above.
// - VA_OUT_REG_EN defined:
//   - g_va_o/g_vc_id_o are registered and appear one cycle after the requesting cycle; owned/pointers update at that same edge.
//   - A requester whose g_va_o is high this cycle is masked out of stage 1, so a still-held r_va_i cannot be double-granted.
//   - Reset clears the output registers.
// TESTING
// Config N_OF_REQUEST=3, N_OF_VN=2, N_OF_VC=2, default build unless stated.
// - T1 Contention and busy mask:
//   - Stimulus: fifo_pointer_state_i=4'b1010, r_va_i=3'b101, r_vc_requested_i=12'b1100_0000_1100.
//   - Response: g_va_o=3'b001, g_vc_id_o=12'h004; next edge vc_owned_o=4'b0100.
// - T2 No re-grant, then release:
//   - Stimulus: hold req2 only. Response: no grant (VC2 owned, VC3 busy).
//   - Stimulus: pulse release_vc_i=4'b0100. Response: following cycle g_va_o=3'b100, g_vc_id_o=12'h400.
// - T3 Input round-robin:
//   - Stimulus: req0 mask 4'b1111, all free. Response: VC0 granted.
//   - Stimulus: release VC0, re-request. Response: VC1 granted, then VC2, then VC3, then VC0.
// - T4 Output round-robin:
//   - Stimulus: r_va_i=3'b111, all masks 4'b0001, release VC0 every cycle.
//   - Response: grant order req0, req1, req2, req0.
// - T5 Async reset mid-operation:
//   - Stimulus: with vc_owned_o=4'b1111, assert rst between edges.
//   - Response: vc_owned_o=0 and g_va_o=0 immediately; after deassert, req0 mask 1111 gets VC0.
// - T6 VA_OUT_REG_EN defined:
//   - Stimulus: T1 stimulus.
//   - Response: g_va_o=3'b001 one cycle later; the held r_va_i[0] gets no second grant.

Source files
------------

// File: rtl/vc_allocator_rr_if.sv
// rtl/vc_allocator_rr_if.sv - request/grant/release bundle between out-buffers and the VC allocator
interface vc_allocator_rr_if #(
    parameter int N_OF_REQUEST = 3,
    parameter int N_TOT_OF_VC  = 4
);
    logic [N_OF_REQUEST-1:0]             r_va_i;
    logic [N_OF_REQUEST*N_TOT_OF_VC-1:0] r_vc_requested_i;
    logic [N_TOT_OF_VC-1:0]              fifo_pointer_state_i;
    logic [N_TOT_OF_VC-1:0]              release_vc_i;
    logic [N_OF_REQUEST-1:0]             g_va_o;
    logic [N_OF_REQUEST*N_TOT_OF_VC-1:0] g_vc_id_o;
    logic [N_TOT_OF_VC-1:0]              vc_owned_o;

    modport master (
        output r_va_i, r_vc_requested_i, fifo_pointer_state_i, release_vc_i,
        input  g_va_o, g_vc_id_o, vc_owned_o
    );

    modport slave (
        input  r_va_i, r_vc_requested_i, fifo_pointer_state_i, release_vc_i,
        output g_va_o, g_vc_id_o, vc_owned_o
    );
endinterface

// File: rtl/vc_allocator_rr.sv
// rtl/vc_allocator_rr.sv - separable two-stage round-robin VC allocator with ownership table
// Optional registered grant outputs: define VA_OUT_REG_EN.
module vc_allocator_rr #(
    parameter  int N_OF_REQUEST        = 3,
    parameter  int N_OF_VN             = 2,
    parameter  int N_OF_VC             = 2,
    localparam int N_TOT_OF_VC         = N_OF_VN * N_OF_VC,
    localparam int N_BITS_N_OF_REQUEST = (N_OF_REQUEST > 1) ? $clog2(N_OF_REQUEST) : 1,
    localparam int VC_IDX_W            = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1
) (
    input logic               clk,
    input logic               rst,
    vc_allocator_rr_if.slave  va
);
    logic [N_TOT_OF_VC-1:0]                    owned;
    logic [N_TOT_OF_VC-1:0]                    avail;
    logic [N_OF_REQUEST-1:0][VC_IDX_W-1:0]     req_ptr;
    logic [N_TOT_OF_VC-1:0][N_BITS_N_OF_REQUEST-1:0] vc_ptr;
    logic [N_OF_REQUEST-1:0]                   eligible;
    logic [N_OF_REQUEST-1:0][N_TOT_OF_VC-1:0]  pick1;
    logic [N_OF_REQUEST-1:0][N_TOT_OF_VC-1:0]  gnt;
    logic [N_TOT_OF_VC-1:0]                    gnt_vc;
    logic [N_OF_REQUEST-1:0]                   gnt_va;

    assign avail = ~owned & ~va.fifo_pointer_state_i;

`ifdef VA_OUT_REG_EN
    logic [N_OF_REQUEST-1:0]                   g_va_q;
    logic [N_OF_REQUEST*N_TOT_OF_VC-1:0]       g_vc_id_q;

    // A requester still showing last cycle's grant must not win again on a held request.
    assign eligible = va.r_va_i & ~g_va_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_va_q    <= '0;
            g_vc_id_q <= '0;
        end else begin
            g_va_q    <= gnt_va;
            g_vc_id_q <= gnt;
        end
    end

    assign va.g_va_o    = g_va_q;
    assign va.g_vc_id_o = g_vc_id_q;
`else
    assign eligible = va.r_va_i;
    // Same-cycle grant; forced quiet while reset is held.
    assign va.g_va_o    = rst ? '0 : gnt_va;
    assign va.g_vc_id_o = rst ? '0 : gnt;
`endif

    assign va.vc_owned_o = owned;

    // Stage 1: each eligible requester picks its first available candidate at/after its pointer.
    always_comb begin
        logic [N_TOT_OF_VC-1:0] cand;
        logic                   found;
        int                     idx;
        pick1 = '0;
        for (int i = 0; i < N_OF_REQUEST; i++) begin
            cand  = eligible[i] ? (va.r_vc_requested_i[i*N_TOT_OF_VC +: N_TOT_OF_VC] & avail) : '0;
            found = 1'b0;
            for (int k = 0; k < N_TOT_OF_VC; k++) begin
                idx = (int'(req_ptr[i]) + k) % N_TOT_OF_VC;
                if (!found && cand[idx]) begin
                    pick1[i][idx] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
    end

    // Stage 2: each VC accepts the first requester at/after its pointer among those that picked it.
    always_comb begin
        logic found;
        int   idx;
        gnt = '0;
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            found = 1'b0;
            for (int k = 0; k < N_OF_REQUEST; k++) begin
                idx = (int'(vc_ptr[v]) + k) % N_OF_REQUEST;
                if (!found && pick1[idx][v]) begin
                    gnt[idx][v] = 1'b1;
                    found       = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_vc = '0;
        gnt_va = '0;
        for (int i = 0; i < N_OF_REQUEST; i++) begin
            gnt_va[i] = |gnt[i];
            gnt_vc    = gnt_vc | gnt[i];
        end
    end

    // Releasing an unowned VC is harmless; a granted VC is never in the release set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owned   <= '0;
            req_ptr <= '0;
            vc_ptr  <= '0;
        end else begin
            owned <= (owned & ~va.release_vc_i) | gnt_vc;
            for (int i = 0; i < N_OF_REQUEST; i++) begin
                for (int v = 0; v < N_TOT_OF_VC; v++) begin
                    if (gnt[i][v]) begin
                        req_ptr[i] <= VC_IDX_W'((v + 1) % N_TOT_OF_VC);
                        vc_ptr[v]  <= N_BITS_N_OF_REQUEST'((i + 1) % N_OF_REQUEST);
                    end
                end
            end
        end
    end
endmodule
